// File: rtl/datamem_pkg.sv
// Shared response codes, FSM state types and the word-index range check
// used by the NPU data-memory AXI4-Lite responder.
package datamem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

    // Takes 32-bit operands so callers can pass any index width without
    // the comparison collapsing to a constant.
    function automatic logic in_range(input int unsigned idx, input int unsigned depth);
        return idx < depth;
    endfunction

endpackage

// File: rtl/datamem_array.sv
// Word memory with one byte-strobed write port and two registered read
// ports (AXI and core). Synchronous clear empties every word and both ports.
module datamem_array #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned IW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [31:0]   wr_data,
    input  logic [3:0]    wr_strb,
    input  logic          rd_en,
    input  logic          rd_zero,
    input  logic [IW-1:0] rd_idx,
    output logic [31:0]   rd_data,
    input  logic [IW-1:0] core_idx,
    output logic [31:0]   core_data
);

    logic [31:0] mem [DEPTH];

    // Reads sample the array before this edge's write lands, which gives
    // the pre-write value on a same-cycle collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            rd_data   <= '0;
            core_data <= '0;
        end else begin
            if (wr_en) begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_strb[b]) begin
                        mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                    end
                end
            end
            if (rd_en) begin
                rd_data <= rd_zero ? 32'h0 : mem[rd_idx];
            end
            core_data <= mem[core_idx];
        end
    end

endmodule

// File: rtl/axi4lite_datamem_slave.sv
// AXI4-Lite responder for the NPU data memory: independent write and read
// channel FSMs in front of datamem_array, plus a 1-cycle core read port.
module axi4lite_datamem_slave
    import datamem_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
    parameter int unsigned MEM_DEPTH          = 16
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    input  logic [$clog2(MEM_DEPTH)-1:0]    core_raddr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   core_rdata,
    output wr_state_t                       dbg_wr_state,
    output rd_state_t                       dbg_rd_state
);

    localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned IW = $clog2(MEM_DEPTH);

    // Handshake rule on every channel: a beat transfers on the rising edge
    // where valid and ready are both high; ready is a register and never
    // looks at valid in the same cycle, and a raised valid (with its
    // payload) stays put until that transfer edge.

    wr_state_t          wr_state;
    rd_state_t          rd_state;
    logic               aw_full;
    logic               w_full;
    logic [AW-1:2]      aw_addr_q;
    logic [31:0]        w_data_q;
    logic [3:0]         w_strb_q;

    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic wr_commit;
    logic aw_in_range;
    logic ar_in_range;
    logic unused_ok;

    assign aw_hs       = s00_axi_awvalid && s00_axi_awready;
    assign w_hs        = s00_axi_wvalid && s00_axi_wready;
    assign ar_hs       = s00_axi_arvalid && s00_axi_arready;
    assign wr_commit   = (wr_state == WR_IDLE) && aw_full && w_full;
    assign aw_in_range = in_range(32'(aw_addr_q), MEM_DEPTH);
    assign ar_in_range = in_range(32'(s00_axi_araddr[AW-1:2]), MEM_DEPTH);

    assign dbg_wr_state = wr_state;
    assign dbg_rd_state = rd_state;
    assign unused_ok    = ^{s00_axi_awprot, s00_axi_arprot,
                            s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    datamem_array #(
        .DEPTH (MEM_DEPTH),
        .IW    (IW)
    ) u_mem (
        .clk       (s00_axi_aclk),
        .rst       (s00_axi_areset),
        .wr_en     (wr_commit && aw_in_range),
        .wr_idx    (aw_addr_q[IW+1:2]),
        .wr_data   (w_data_q),
        .wr_strb   (w_strb_q),
        .rd_en     (ar_hs),
        .rd_zero   (!ar_in_range),
        .rd_idx    (s00_axi_araddr[IW+1:2]),
        .rd_data   (s00_axi_rdata),
        .core_idx  (core_raddr),
        .core_data (core_rdata)
    );

    // Write channel: AW and W fill their own slots in any order; the cycle
    // both are full commits to the array and raises the response.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            wr_state        <= WR_IDLE;
            aw_full         <= 1'b0;
            w_full          <= 1'b0;
            aw_addr_q       <= '0;
            w_data_q        <= '0;
            w_strb_q        <= '0;
            s00_axi_awready <= 1'b0;
            s00_axi_wready  <= 1'b0;
            s00_axi_bvalid  <= 1'b0;
            s00_axi_bresp   <= RESP_OKAY;
        end else begin
            unique case (wr_state)
                WR_IDLE: begin
                    if (wr_commit) begin
                        wr_state        <= WR_RESP;
                        aw_full         <= 1'b0;
                        w_full          <= 1'b0;
                        s00_axi_awready <= 1'b0;
                        s00_axi_wready  <= 1'b0;
                        s00_axi_bvalid  <= 1'b1;
                        s00_axi_bresp   <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        if (aw_hs) begin
                            aw_full   <= 1'b1;
                            aw_addr_q <= s00_axi_awaddr[AW-1:2];
                        end
                        if (w_hs) begin
                            w_full   <= 1'b1;
                            w_data_q <= s00_axi_wdata;
                            w_strb_q <= s00_axi_wstrb;
                        end
                        s00_axi_awready <= !(aw_full || aw_hs);
                        s00_axi_wready  <= !(w_full || w_hs);
                    end
                end
                WR_RESP: begin
                    if (s00_axi_bready) begin
                        wr_state        <= WR_IDLE;
                        s00_axi_bvalid  <= 1'b0;
                        s00_axi_awready <= 1'b1;
                        s00_axi_wready  <= 1'b1;
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

    // Read channel: the array registers rdata on the AR edge, so rvalid and
    // rresp rise together with it and all three hold until rready.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            rd_state        <= RD_IDLE;
            s00_axi_arready <= 1'b0;
            s00_axi_rvalid  <= 1'b0;
            s00_axi_rresp   <= RESP_OKAY;
        end else begin
            unique case (rd_state)
                RD_IDLE: begin
                    if (ar_hs) begin
                        rd_state        <= RD_DATA;
                        s00_axi_arready <= 1'b0;
                        s00_axi_rvalid  <= 1'b1;
                        s00_axi_rresp   <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        s00_axi_arready <= 1'b1;
                    end
                end
                RD_DATA: begin
                    if (s00_axi_rready) begin
                        rd_state        <= RD_IDLE;
                        s00_axi_rvalid  <= 1'b0;
                        s00_axi_arready <= 1'b1;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4lite_datamem_slave.sv
// Self-checking bench for axi4lite_datamem_slave: vector table, hand-written
// timing sequences and random traffic against a word-array reference model.
module tb_axi4lite_datamem_slave;
    import datamem_pkg::*;

    localparam int AW    = 7;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          areset;
    logic [AW-1:0] awaddr;
    logic [2:0]    awprot;
    logic          awvalid;
    logic          awready;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic [2:0]    arprot;
    logic          arvalid;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;
    logic [3:0]    core_raddr;
    logic [31:0]   core_rdata;
    wr_state_t     dbg_wr_state;
    rd_state_t     dbg_rd_state;

    int total = 0;
    int bad   = 0;
    logic [31:0] model_mem [DEPTH];

    typedef struct {
        bit          is_wr;
        logic [6:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs [14];

    axi4lite_datamem_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (AW),
        .MEM_DEPTH          (DEPTH)
    ) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_areset  (areset),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .core_raddr      (core_raddr),
        .core_rdata      (core_rdata),
        .dbg_wr_state    (dbg_wr_state),
        .dbg_rd_state    (dbg_rd_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out waiting on the DUT", name);
    endtask

    // ---------------- reference model ----------------
    task automatic model_write(input logic [6:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, output logic [1:0] resp);
        int idx;
        idx = int'(addr) / 4;
        if (idx < DEPTH) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) model_mem[idx][8*b +: 8] = data[8*b +: 8];
            end
            resp = RESP_OKAY;
        end else begin
            resp = RESP_SLVERR;
        end
    endtask

    task automatic model_read(input logic [6:0] addr, output logic [31:0] data,
                              output logic [1:0] resp);
        int idx;
        idx = int'(addr) / 4;
        if (idx < DEPTH) begin
            data = model_mem[idx];
            resp = RESP_OKAY;
        end else begin
            data = 32'h0;
            resp = RESP_SLVERR;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    endtask

    // ---------------- drivers (called at a negedge, return at a negedge) ----------------
    task automatic axi_write(input logic [6:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        bit a_done;
        bit w_done;
        bit a_hs;
        bit w_hs;
        int c;
        a_done = 0;
        w_done = 0;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        c = 0;
        while (!(a_done && w_done) && c < 50) begin
            a_hs = awvalid && awready;
            w_hs = wvalid && wready;
            @(negedge clk);
            c++;
            if (a_hs) begin a_done = 1; awvalid = 1'b0; end
            if (w_hs) begin w_done = 1; wvalid = 1'b0; end
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        if (!(a_done && w_done)) timeout("write addr/data handshake");
        c = 0;
        while (!bvalid && c < 50) begin
            @(negedge clk);
            c++;
        end
        resp = bresp;
        if (!bvalid) begin
            timeout("write response");
            resp = 2'bxx;
        end
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [6:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        bit done;
        int c;
        done = 0;
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        c = 0;
        while (!done && c < 50) begin
            done = arvalid && arready;
            @(negedge clk);
            c++;
        end
        arvalid = 1'b0;
        if (!done) timeout("read address handshake");
        c = 0;
        while (!rvalid && c < 50) begin
            @(negedge clk);
            c++;
        end
        data = rdata;
        resp = rresp;
        if (!rvalid) begin
            timeout("read data");
            data = 'x;
            resp = 2'bxx;
        end
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic check_core(input int idx);
        core_raddr = 4'(idx);
        @(negedge clk);
        check($sformatf("core_rdata[%0d]", idx), core_rdata, model_mem[idx]);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [31:0] d;
        logic [31:0] old_v;
        logic [31:0] new_v;
        logic [1:0]  r;
        logic [1:0]  mr;
        logic [31:0] md;
        logic [6:0]  a;
        logic [3:0]  s;

        areset = 1'b1;
        awaddr = '0; awprot = 3'b0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = 3'b0; arvalid = 1'b0; rready = 1'b0;
        core_raddr = '0;
        model_clear();

        repeat (3) @(negedge clk);
        check("reset awready", 32'(awready), 0);
        check("reset wready", 32'(wready), 0);
        check("reset arready", 32'(arready), 0);
        check("reset bvalid", 32'(bvalid), 0);
        check("reset rvalid", 32'(rvalid), 0);
        check("reset bresp", 32'(bresp), 0);
        check("reset rresp", 32'(rresp), 0);
        check("reset rdata", rdata, 0);
        check("reset core_rdata", core_rdata, 0);
        areset = 1'b0;
        @(negedge clk);
        check("idle awready", 32'(awready), 1);
        check("idle wready", 32'(wready), 1);
        check("idle arready", 32'(arready), 1);

        // Vector table: basic words, byte strobes, out-of-range index.
        vecs[0]  = '{1, 7'h00, 32'h1, 4'hF, 32'h0, RESP_OKAY};
        vecs[1]  = '{1, 7'h04, 32'h2, 4'hF, 32'h0, RESP_OKAY};
        vecs[2]  = '{1, 7'h08, 32'h3, 4'hF, 32'h0, RESP_OKAY};
        vecs[3]  = '{1, 7'h0C, 32'h4, 4'hF, 32'h0, RESP_OKAY};
        vecs[4]  = '{0, 7'h00, 32'h0, 4'h0, 32'h1, RESP_OKAY};
        vecs[5]  = '{0, 7'h04, 32'h0, 4'h0, 32'h2, RESP_OKAY};
        vecs[6]  = '{0, 7'h0B, 32'h0, 4'h0, 32'h3, RESP_OKAY};
        vecs[7]  = '{0, 7'h0C, 32'h0, 4'h0, 32'h4, RESP_OKAY};
        vecs[8]  = '{1, 7'h08, 32'hAABBCCDD, 4'hF, 32'h0, RESP_OKAY};
        vecs[9]  = '{1, 7'h08, 32'h11223344, 4'b0101, 32'h0, RESP_OKAY};
        vecs[10] = '{0, 7'h08, 32'h0, 4'h0, 32'hAA22CC44, RESP_OKAY};
        vecs[11] = '{1, 7'h40, 32'hDEADBEEF, 4'hF, 32'h0, RESP_SLVERR};
        vecs[12] = '{0, 7'h40, 32'h0, 4'h0, 32'h0, RESP_SLVERR};
        vecs[13] = '{0, 7'h00, 32'h0, 4'h0, 32'h1, RESP_OKAY};

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].is_wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r);
                model_write(vecs[i].addr, vecs[i].data, vecs[i].strb, mr);
                check($sformatf("vec%0d bresp", i), 32'(r), 32'(vecs[i].exp_resp));
            end else begin
                axi_read(vecs[i].addr, d, r);
                check($sformatf("vec%0d rdata", i), d, vecs[i].exp_data);
                check($sformatf("vec%0d rresp", i), 32'(r), 32'(vecs[i].exp_resp));
            end
        end

        // AW first, W three cycles later.
        awaddr = 7'h04; awvalid = 1'b1; bready = 1'b0;
        check("late-w awready before", 32'(awready), 1);
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("late-w awready held low", 32'(awready), 0);
            check("late-w bvalid early", 32'(bvalid), 0);
            if (i < 2) @(negedge clk);
        end
        wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1;
        check("late-w wready", 32'(wready), 1);
        @(negedge clk);
        wvalid = 1'b0;
        check("late-w bvalid at capture", 32'(bvalid), 0);
        @(negedge clk);
        check("late-w bvalid after capture", 32'(bvalid), 1);
        check("late-w bresp", 32'(bresp), 32'(RESP_OKAY));
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        model_write(7'h04, 32'h55, 4'hF, mr);
        check_core(1);

        // Responses held while bready/rready stay low.
        awaddr = 7'h0C; wdata = 32'h600DCAFE; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; araddr = 7'h08; arvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(negedge clk);
        model_read(7'h08, md, mr);
        for (int i = 0; i < 5; i++) begin
            check("hold bvalid", 32'(bvalid), 1);
            check("hold bresp", 32'(bresp), 32'(RESP_OKAY));
            check("hold rvalid", 32'(rvalid), 1);
            check("hold rdata", rdata, md);
            check("hold rresp", 32'(rresp), 32'(mr));
            check("hold awready", 32'(awready), 0);
            check("hold wready", 32'(wready), 0);
            check("hold arready", 32'(arready), 0);
            check("hold wr state", 32'(dbg_wr_state), 32'(WR_RESP));
            @(negedge clk);
        end
        bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        bready = 1'b0; rready = 1'b0;
        check("hold bvalid released", 32'(bvalid), 0);
        check("hold rvalid released", 32'(rvalid), 0);
        model_write(7'h0C, 32'h600DCAFE, 4'hF, mr);
        check_core(3);

        // AR and core read land on the same edge as a write commit.
        old_v = 32'h12345678;
        new_v = 32'hCAFEF00D;
        axi_write(7'h14, old_v, 4'hF, r);
        model_write(7'h14, old_v, 4'hF, mr);
        awaddr = 7'h14; wdata = new_v; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 7'h14; arvalid = 1'b1; core_raddr = 4'd5;
        @(negedge clk);
        arvalid = 1'b0;
        check("collide bvalid", 32'(bvalid), 1);
        check("collide rvalid", 32'(rvalid), 1);
        check("collide rdata pre-write", rdata, old_v);
        check("collide core pre-write", core_rdata, old_v);
        @(negedge clk);
        check("collide core post-write", core_rdata, new_v);
        bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        bready = 1'b0; rready = 1'b0;
        model_write(7'h14, new_v, 4'hF, mr);
        axi_read(7'h14, d, r);
        check("collide readback", d, new_v);

        // Random traffic against the model, including out-of-range indices.
        for (int i = 0; i < 60; i++) begin
            a = 7'($urandom_range(0, 71));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                axi_write(a, d, s, r);
                model_write(a, d, s, mr);
                check($sformatf("rand%0d bresp @%02h", i, a), 32'(r), 32'(mr));
            end else begin
                axi_read(a, d, r);
                model_read(a, md, mr);
                check($sformatf("rand%0d rdata @%02h", i, a), d, md);
                check($sformatf("rand%0d rresp @%02h", i, a), 32'(r), 32'(mr));
            end
            check_core($urandom_range(0, DEPTH - 1));
        end

        // Reset with an AW captured and rvalid pending.
        axi_write(7'h00, 32'hDEADBEEF, 4'hF, r);
        model_write(7'h00, 32'hDEADBEEF, 4'hF, mr);
        core_raddr = 4'd0;
        awaddr = 7'h10; awvalid = 1'b1;
        araddr = 7'h00; arvalid = 1'b1; rready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; arvalid = 1'b0;
        check("pre-reset rvalid", 32'(rvalid), 1);
        check("pre-reset core_rdata", core_rdata, 32'hDEADBEEF);
        areset = 1'b1;
        @(negedge clk);
        check("in-reset bvalid", 32'(bvalid), 0);
        check("in-reset rvalid", 32'(rvalid), 0);
        check("in-reset awready", 32'(awready), 0);
        check("in-reset arready", 32'(arready), 0);
        check("in-reset rdata", rdata, 0);
        check("in-reset core_rdata", core_rdata, 0);
        areset = 1'b0;
        model_clear();
        @(negedge clk);
        check("post-reset awready", 32'(awready), 1);
        check("post-reset wready", 32'(wready), 1);
        check_core(0);
        check_core(4);
        axi_write(7'h00, 32'h0BADF00D, 4'hF, r);
        model_write(7'h00, 32'h0BADF00D, 4'hF, mr);
        check("post-reset bresp", 32'(r), 32'(RESP_OKAY));
        axi_read(7'h00, d, r);
        check("post-reset readback", d, 32'h0BADF00D);
        axi_read(7'h10, d, r);
        check("post-reset dropped write", d, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
